// File: rtl/key_display_pkg.sv
// Shared constants, FSM state type and key/segment helpers for key_entry_display.
package key_display_pkg;

  // Segment patterns, bit6=g .. bit0=a, active-high.
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kd_state_e;

  // key[3] is digit 1 (code 0) down to key[0] as digit 4 (code 3).
  function automatic logic [1:0] key_to_code(input logic [3:0] key);
    logic [1:0] code;
    code = 2'd0;
    if (key[3])      code = 2'd0;
    else if (key[2]) code = 2'd1;
    else if (key[1]) code = 2'd2;
    else if (key[0]) code = 2'd3;
    return code;
  endfunction

  function automatic logic [6:0] code_to_seg(input logic [1:0] code);
    logic [6:0] seg;
    case (code)
      2'd0:    seg = SEG_1;
      2'd1:    seg = SEG_2;
      2'd2:    seg = SEG_3;
      default: seg = SEG_4;
    endcase
    return seg;
  endfunction

  function automatic logic is_one_hot(input logic [3:0] key);
    return (key != 4'd0) && ((key & 4'(key - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/key_sync_debounce.sv
// Synchronises the raw key pad and debounces presses/releases.
// accept_pulse / invalid_pulse / accept_code are combinational strobes,
// valid during the cycle in which a press becomes debounced; the parent
// registers them.
//
// state       | meaning
// ------------+-----------------------------------------------------
// ST_IDLE     | no key seen, ready for a new press
// ST_DEBOUNCE | candidate pattern seen, counting stable cycles
// ST_HELD     | press accepted (or rejected), waiting for release
// ST_RELEASE  | keys released, counting stable zero cycles
module key_sync_debounce
  import key_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] key,
  output logic       accept_pulse,
  output logic [1:0] accept_code,
  output logic       invalid_pulse
);

  localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  // cnt holds the number of stable cycles already seen; the next stable
  // sample completes the run when cnt equals DB_LAST.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic [3:0]      sync1_q, key_s_q;
  logic [3:0]      cand_q, cand_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  kd_state_e       state_q, state_d;
  logic            judge_en;
  logic [3:0]      judge_key;

  // Two-flop synchroniser on the raw pins.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= 4'd0;
      key_s_q <= 4'd0;
    end else begin
      sync1_q <= key;
      key_s_q <= sync1_q;
    end
  end

  // FSM state, candidate and run counter registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a completed press run is judged one-hot or not.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    judge_en  = 1'b0;
    judge_key = cand_q;
    case (state_q)
      ST_IDLE: begin
        if (key_s_q != 4'd0) begin
          cand_d = key_s_q;
          cnt_d  = DB_ONE;
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = ST_HELD;
            judge_en  = 1'b1;
            judge_key = key_s_q;
          end else begin
            state_d = ST_DEBOUNCE;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (key_s_q == 4'd0) begin
          state_d = ST_IDLE;
        end else if (key_s_q != cand_q) begin
          // A different pattern restarts the run.
          cand_d = key_s_q;
          cnt_d  = DB_ONE;
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = ST_HELD;
            judge_en  = 1'b1;
            judge_key = key_s_q;
          end
        end else if (cnt_q == DB_LAST) begin
          state_d   = ST_HELD;
          judge_en  = 1'b1;
          judge_key = cand_q;
        end else begin
          cnt_d = cnt_q + DB_ONE;
        end
      end
      ST_HELD: begin
        if (key_s_q == 4'd0) begin
          cnt_d = DB_ONE;
          if (DEBOUNCE_CYCLES == 1) state_d = ST_IDLE;
          else                      state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (key_s_q != 4'd0) begin
          state_d = ST_HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + DB_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Press verdict strobes.
  always_comb begin
    accept_pulse  = judge_en && is_one_hot(judge_key);
    invalid_pulse = judge_en && !is_one_hot(judge_key);
    accept_code   = key_to_code(judge_key);
  end

endmodule

// File: rtl/key_entry_display.sv
// Key entry buffer with 7-segment drive for the lock keypad.
// Build option: define KEY_ENTRY_MASK_EN to show a dash on every occupied
// display instead of the digit (code_out still carries the real digits).
module key_entry_display
  import key_display_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W          = $clog2(DIGITS + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [3:0]            key,
  input  logic                  clear,
  output logic [7*DIGITS-1:0]   seg_out,
  output logic [2*DIGITS-1:0]   code_out,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  entry_pulse,
  output logic                  invalid_pulse
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);

  logic             accept;
  logic             reject;
  logic [1:0]       accept_code;

  logic [1:0]       buf_q [DIGITS];
  logic [1:0]       buf_d [DIGITS];
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             entry_pulse_q, entry_pulse_d;
  logic             invalid_pulse_q, invalid_pulse_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;

  key_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock         (clock),
    .reset_n       (reset_n),
    .key           (key),
    .accept_pulse  (accept),
    .accept_code   (accept_code),
    .invalid_pulse (reject)
  );

  // Buffer shift/clear, count and display patterns for the next cycle.
  always_comb begin
    buf_d           = buf_q;
    count_d         = count_q;
    entry_pulse_d   = accept;
    invalid_pulse_d = reject;
    seg_d           = '0;
    if (clear) begin
      // Clear beats a simultaneous accept; the strobe still fires.
      for (int d = 0; d < DIGITS; d++) buf_d[d] = 2'd0;
      count_d = '0;
    end else if (accept && (count_q != CNT_FULL)) begin
      for (int d = DIGITS - 1; d > 0; d--) buf_d[d] = buf_q[d-1];
      buf_d[0] = accept_code;
      count_d  = count_q + CNT_W'(1);
    end
    full_d = (count_d == CNT_FULL);
    for (int d = 0; d < DIGITS; d++) begin
      if (CNT_W'(d) < count_d) begin
`ifdef KEY_ENTRY_MASK_EN
        seg_d[7*d +: 7] = SEG_DASH;
`else
        seg_d[7*d +: 7] = code_to_seg(buf_d[d]);
`endif
      end else begin
        buf_d[d]        = 2'd0;
        seg_d[7*d +: 7] = SEG_BLANK;
      end
    end
  end

  // Output and buffer registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int d = 0; d < DIGITS; d++) buf_q[d] <= 2'd0;
      count_q         <= '0;
      full_q          <= 1'b0;
      entry_pulse_q   <= 1'b0;
      invalid_pulse_q <= 1'b0;
      seg_q           <= '0;
    end else begin
      buf_q           <= buf_d;
      count_q         <= count_d;
      full_q          <= full_d;
      entry_pulse_q   <= entry_pulse_d;
      invalid_pulse_q <= invalid_pulse_d;
      seg_q           <= seg_d;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_code
    assign code_out[2*g +: 2] = buf_q[g];
  end

  assign seg_out       = seg_q;
  assign count         = count_q;
  assign full          = full_q;
  assign entry_pulse   = entry_pulse_q;
  assign invalid_pulse = invalid_pulse_q;

endmodule

// File: tb/tb_key_entry_display.sv
// Self-checking bench for key_entry_display: directed scenarios followed by
// random key traffic, all compared each cycle against a run-length model.
module tb_key_entry_display;

  localparam int DIGITS = 4;
  localparam int DB     = 4;
  localparam int CNT_W  = $clog2(DIGITS + 1);

  logic                clock = 1'b0;
  logic                reset_n;
  logic [3:0]          key;
  logic                clear;
  logic [7*DIGITS-1:0] seg_out;
  logic [2*DIGITS-1:0] code_out;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                entry_pulse;
  logic                invalid_pulse;

  key_entry_display #(.DIGITS(DIGITS), .DEBOUNCE_CYCLES(DB)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .key           (key),
    .clear         (clear),
    .seg_out       (seg_out),
    .code_out      (code_out),
    .count         (count),
    .full          (full),
    .entry_pulse   (entry_pulse),
    .invalid_pulse (invalid_pulse)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int n_ent  = 0;
  int n_inv  = 0;

  // Reference model: entered digits (1..4), newest at index 0.
  int         q[$];
  logic [3:0] m_sync1, m_keys, m_last;
  bit         m_armed;
  int         m_run, m_zrun;
  bit         m_entry, m_inv;
  logic [6:0] seg_tab [5];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] shown(input int digit);
`ifdef KEY_ENTRY_MASK_EN
    return 7'b1000000;
`else
    return seg_tab[digit];
`endif
  endfunction

  task automatic model_edge(input logic [3:0] k, input logic c, input logic r);
    logic [3:0] ks;
    int dig;
    if (!r) begin
      q.delete();
      m_sync1 = 0; m_keys = 0; m_last = 0;
      m_armed = 1; m_run = 0; m_zrun = 0;
      m_entry = 0; m_inv = 0;
      return;
    end
    ks = m_keys; m_keys = m_sync1; m_sync1 = k;
    m_entry = 0; m_inv = 0; dig = 0;
    if (m_armed) begin
      if (ks == 0) m_run = 0;
      else if (ks == m_last && m_run > 0) m_run++;
      else begin m_last = ks; m_run = 1; end
      if (m_run == DB) begin
        m_armed = 0; m_run = 0; m_zrun = 0;
        if ($countones(ks) == 1) begin
          m_entry = 1;
          for (int i = 0; i < 4; i++) if (ks[i]) dig = 4 - i;
        end else m_inv = 1;
      end
    end else begin
      if (ks != 0) m_zrun = 0;
      else begin
        m_zrun++;
        if (m_zrun == DB) begin m_armed = 1; m_run = 0; end
      end
    end
    if (c) q.delete();
    else if (m_entry && q.size() < DIGITS) q.push_front(dig);
  endtask

  task automatic compare_all();
    logic [7*DIGITS-1:0] es;
    logic [2*DIGITS-1:0] ec;
    es = '0; ec = '0;
    for (int d = 0; d < q.size(); d++) begin
      es[7*d +: 7] = shown(q[d]);
      ec[2*d +: 2] = 2'(q[d] - 1);
    end
    check("entry_pulse", entry_pulse, m_entry);
    check("invalid_pulse", invalid_pulse, m_inv);
    check("count", count, q.size());
    check("full", full, q.size() == DIGITS);
    check("code_out", code_out, ec);
    check("seg_out", seg_out, es);
  endtask

  task automatic cyc(input logic [3:0] k, input logic c, input logic r);
    key = k; clear = c; reset_n = r;
    @(posedge clock);
    model_edge(k, c, r);
    @(negedge clock);
    compare_all();
    n_ent += int'(entry_pulse);
    n_inv += int'(invalid_pulse);
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int rel);
    for (int i = 0; i < hold; i++) cyc(k, 0, 1);
    for (int i = 0; i < rel; i++) cyc(4'd0, 0, 1);
  endtask

  initial begin
    int first_at;
    logic [3:0] k;
    logic [27:0] exp_full_seg;
    seg_tab[0] = 7'b0000000; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
    seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110;
`ifdef KEY_ENTRY_MASK_EN
    exp_full_seg = {4{7'b1000000}};
`else
    exp_full_seg = {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110};
`endif
    key = 0; clear = 0; reset_n = 0;

    // Reset, then first press latency.
    cyc(4'd0, 0, 0);
    cyc(4'd0, 0, 0);
    check("reset_count", count, 0);
    check("reset_seg", seg_out, 0);
    first_at = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(4'b1000, 0, 1);
      if (entry_pulse && first_at == 0) first_at = i;
    end
    check("latency", first_at, DB + 2);
    check("first_seg", seg_out[6:0], shown(1));
    check("first_code", code_out[1:0], 2'b00);
    check("first_count", count, 1);
    press(4'd0, 0, 8);

    // Fill with 2,3,4 then a fifth press while full.
    press(4'b0100, 8, 8);
    press(4'b0010, 8, 8);
    press(4'b0001, 8, 8);
    check("fill_code", code_out, 8'b00011011);
    check("fill_seg", seg_out, exp_full_seg);
    check("fill_full", full, 1);
    n_ent = 0;
    press(4'b1000, 8, 8);
    check("full_entry", n_ent, 1);
    check("full_code", code_out, 8'b00011011);
    check("full_count", count, 4);

    // Short bounces and a multi-hot press.
    n_ent = 0; n_inv = 0;
    for (int i = 0; i < 3; i++) press(4'b1000, 2, 2);
    press(4'b0110, 10, 8);
    check("bounce_entry", n_ent, 0);
    check("multi_invalid", n_inv, 1);
    check("multi_count", count, 4);

    // Long hold and a one-cycle release glitch.
    cyc(4'd0, 1, 1);
    n_ent = 0;
    press(4'b0100, 50, 8);
    check("hold_entry", n_ent, 1);
    n_ent = 0;
    press(4'b0010, 20, 1);
    press(4'b0010, 20, 8);
    check("glitch_entry", n_ent, 1);
    check("glitch_count", count, 2);

    // Clear on the exact accept edge.
    for (int i = 1; i < DB + 2; i++) cyc(4'b1000, 0, 1);
    cyc(4'b1000, 1, 1);
    check("clr_entry", entry_pulse, 1);
    check("clr_count", count, 0);
    check("clr_seg", seg_out, 0);
    press(4'b1000, 4, 8);
    press(4'b0001, 8, 8);
    check("after_clr_count", count, 1);
    check("after_clr_code", code_out[1:0], 2'b11);
    check("after_clr_seg", seg_out[6:0], shown(4));

    // Reset while debouncing discards the candidate.
    for (int i = 0; i < 4; i++) cyc(4'b0010, 0, 1);
    cyc(4'b0010, 0, 0);
    check("rst_outputs", {seg_out, code_out, count, full, entry_pulse, invalid_pulse}, '0);
    n_ent = 0;
    for (int i = 0; i < DB + 1; i++) cyc(4'b0010, 0, 1);
    check("rst_no_early_entry", n_ent, 0);
    cyc(4'b0010, 0, 1);
    check("rst_entry", entry_pulse, 1);
    press(4'b0001, 3, 8);
    check("mask_code", code_out[3:0], 4'b0010);
    check("mask_seg", seg_out[13:0], 14'd0 | {7'd0, shown(3)});

    // Random traffic against the model.
    for (int s = 0; s < 70; s++) begin
      int sel, hold;
      sel = $urandom_range(0, 9);
      if (sel < 6) k = 4'b0001 << $urandom_range(0, 3);
      else if (sel == 6) begin
        k = 4'($urandom_range(0, 15));
        if ($countones(k) < 2) k = 4'b1010;
      end else k = 4'd0;
      hold = $urandom_range(1, 9);
      for (int i = 0; i < hold; i++)
        cyc(k, $urandom_range(0, 19) == 0, $urandom_range(0, 149) != 0);
    end
    press(4'd0, 0, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
